sub_unit_arbiter: RTL and testbench

//   Shares one subtractor_16bit datapath between two requesters (req0, req1).

---
 rtl/sub_unit_arbiter_pkg.sv | 22 ++
 rtl/sub_unit_arbiter_subtractor.sv | 18 +
 rtl/sub_unit_arbiter.sv | 117 +++++++++++
 tb/tb_sub_unit_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sub_unit_arbiter_pkg.sv
// Shared types for the subtract-unit arbiter.
// Width, FSM states and signed overflow rule.
package sub_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic sub_ovf(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic [DATA_W-1:0] d
  );
    return (a[DATA_W-1] != b[DATA_W-1]) &&
           (d[DATA_W-1] != a[DATA_W-1]);
  endfunction

endpackage

// File: rtl/sub_unit_arbiter_subtractor.sv
// Shared 16-bit subtract datapath.
// diff = a + ~b + 1, plus signed overflow flag.
module subtractor_16bit
  import sub_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] diff,
  output logic              ovf
);

  // two's complement subtract and overflow detect
  always_comb begin
    diff = a + ~b + 16'd1;
    ovf  = sub_ovf(a, b, diff);
  end

endmodule

// File: rtl/sub_unit_arbiter.sv
// Two-requester arbiter around one shared subtractor.
// One op in flight; operands and result registered.
module sub_unit_arbiter
  import sub_pkg::*;
#(
  parameter int EXEC_CYCLES = 1,
  parameter bit RR_ENABLE   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b1,
  output logic [1:0]        req_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_diff,
  output logic              resp_overflow,
  output logic              busy
);

  state_t state, state_nx;

  logic [3:0]        cnt;
  logic              rr_last;
  logic              win;
  logic              accept;
  logic [DATA_W-1:0] op_a, op_b;
  logic              op_id;
  logic [DATA_W-1:0] res_diff;
  logic              res_ovf;
  logic              res_id;
  logic [DATA_W-1:0] sub_d;
  logic              sub_o;

  subtractor_16bit u_sub (
    .a    (op_a),
    .b    (op_b),
    .diff (sub_d),
    .ovf  (sub_o)
  );

  // winner select: lone requester, else RR or fixed priority
  always_comb begin
    win = 1'b0;
    unique case (req_valid)
      2'b10:   win = 1'b1;
      2'b11:   win = RR_ENABLE ? ~rr_last : 1'b0;
      default: win = 1'b0;
    endcase
  end

  // next state and accept pulse
  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    req_ready = 2'b00;
    unique case (state)
      IDLE: begin
        if (|req_valid && !rst) begin
          accept    = 1'b1;
          req_ready = win ? 2'b10 : 2'b01;
          state_nx  = EXEC;
        end
      end
      EXEC: begin
        if (cnt == 4'd1) state_nx = RESP;
      end
      RESP: begin
        if (resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // state, operand, counter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rr_last  <= 1'b1;
      op_a     <= '0;
      op_b     <= '0;
      op_id    <= 1'b0;
      res_diff <= '0;
      res_ovf  <= 1'b0;
      res_id   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_a    <= win ? req_a1 : req_a0;
        op_b    <= win ? req_b1 : req_b0;
        op_id   <= win;
        cnt     <= 4'(EXEC_CYCLES);
        rr_last <= win;
      end
      if (state == EXEC) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          res_diff <= sub_d;
          res_ovf  <= sub_o;
          res_id   <= op_id;
        end
      end
    end
  end

  assign resp_valid    = (state == RESP);
  assign resp_id       = res_id;
  assign resp_diff     = res_diff;
  assign resp_overflow = res_ovf;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_sub_unit_arbiter.sv
// Bench for sub_unit_arbiter: RR and fixed-priority
// instances in lockstep against an arithmetic model.
module tb_sub_unit_arbiter;

  localparam int E = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [15:0] req_a0, req_b0, req_a1, req_b1;
  logic        resp_ready;

  logic [1:0]  rdy, f_rdy;
  logic        rv, f_rv;
  logic        rid, f_rid;
  logic [15:0] rd, f_rd;
  logic        ro, f_ro;
  logic        bz, f_bz;

  int checks = 0;
  int errors = 0;
  int last_rr;

  always #5 clk = ~clk;

  sub_unit_arbiter #(.EXEC_CYCLES(E), .RR_ENABLE(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid),
    .req_a0(req_a0), .req_b0(req_b0),
    .req_a1(req_a1), .req_b1(req_b1),
    .req_ready(rdy), .resp_valid(rv), .resp_ready(resp_ready),
    .resp_id(rid), .resp_diff(rd), .resp_overflow(ro), .busy(bz)
  );

  sub_unit_arbiter #(.EXEC_CYCLES(E), .RR_ENABLE(1'b0)) dut_fp (
    .clk(clk), .rst(rst), .req_valid(req_valid),
    .req_a0(req_a0), .req_b0(req_b0),
    .req_a1(req_a1), .req_b1(req_b1),
    .req_ready(f_rdy), .resp_valid(f_rv), .resp_ready(resp_ready),
    .resp_id(f_rid), .resp_diff(f_rd), .resp_overflow(f_ro), .busy(f_bz)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_diff(input logic [15:0] a, b);
    int r;
    r = int'(a) - int'(b) + 65536;
    return 16'(r % 65536);
  endfunction

  function automatic logic m_ovf(input logic [15:0] a, b);
    int r;
    r = int'($signed(a)) - int'($signed(b));
    return (r > 32767) || (r < -32768);
  endfunction

  task automatic chk_idle_out(input string tag);
    chk({tag, "_rdy"}, rdy, 0);
    chk({tag, "_rv"}, rv, 0);
    chk({tag, "_busy"}, bz, 0);
    chk({tag, "_diff"}, rd, 0);
    chk({tag, "_id"}, rid, 0);
    chk({tag, "_ovf"}, ro, 0);
    chk({tag, "_fp_rv"}, f_rv, 0);
    chk({tag, "_fp_diff"}, f_rd, 0);
  endtask

  task automatic run_op(input logic [1:0] v,
                        input logic [15:0] a0, b0, a1, b1,
                        input logic [1:0] pend, input int hold,
                        output int waited, output logic [1:0] g);
    int wr, wf;
    logic [15:0] ea, eb, fa, fb;
    waited = 0;
    req_valid = v;
    req_a0 = a0; req_b0 = b0; req_a1 = a1; req_b1 = b1;
    resp_ready = 1'b0;
    if (v == 2'b10) wr = 1;
    else if (v == 2'b01) wr = 0;
    else wr = (last_rr == 0) ? 1 : 0;
    wf = (v == 2'b10) ? 1 : 0;
    ea = wr ? a1 : a0; eb = wr ? b1 : b0;
    fa = wf ? a1 : a0; fb = wf ? b1 : b0;
    @(negedge clk);
    while (rdy === 2'b00 && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    g = rdy;
    chk("grant", rdy, 32'(1 << wr));
    chk("grant_fp", f_rdy, 32'(1 << wf));
    chk("idle_rv", rv, 0);
    last_rr = wr;
    @(posedge clk);
    #1 req_valid = pend;
    for (int k = 1; k <= E; k++) begin
      @(negedge clk);
      chk("exec_busy", bz, 1);
      chk("exec_rv", rv, 0);
      chk("exec_rdy", rdy, 0);
    end
    @(negedge clk);
    chk("rv", rv, 1);
    chk("id", rid, wr);
    chk("diff", rd, m_diff(ea, eb));
    chk("ovf", ro, m_ovf(ea, eb));
    chk("fp_rv", f_rv, 1);
    chk("fp_id", f_rid, wf);
    chk("fp_diff", f_rd, m_diff(fa, fb));
    chk("fp_ovf", f_ro, m_ovf(fa, fb));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_rv", rv, 1);
      chk("hold_id", rid, wr);
      chk("hold_diff", rd, m_diff(ea, eb));
      chk("hold_ovf", ro, m_ovf(ea, eb));
      chk("hold_rdy", rdy, 0);
      chk("hold_busy", bz, 1);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  initial begin
    int w;
    int n;
    logic [1:0] g;
    logic [1:0] v;
    rst = 1'b1;
    req_valid = 2'b00;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    resp_ready = 1'b0;
    last_rr = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle_out("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    run_op(2'b01, 16'h0002, 16'h0002, 16'h0, 16'h0, 2'b00, 0, w, g);
    chk("first_latency_wait", w, 0);
    run_op(2'b10, 16'h0, 16'h0, 16'h0005, 16'hFFFE, 2'b00, 0, w, g);
    run_op(2'b01, 16'h0004, 16'h0000, 16'h0, 16'h0, 2'b00, 0, w, g);
    run_op(2'b01, 16'h7FFF, 16'hFFFE, 16'h0, 16'h0, 2'b00, 0, w, g);
    run_op(2'b01, 16'h8000, 16'h0001, 16'h0, 16'h0, 2'b00, 0, w, g);
    run_op(2'b01, 16'h8000, 16'hFFFF, 16'h0, 16'h0, 2'b00, 0, w, g);

    run_op(2'b01, 16'h1234, 16'h0034, 16'h0009, 16'h0003,
           2'b10, 5, w, g);
    run_op(2'b10, 16'h0, 16'h0, 16'h0009, 16'h0003, 2'b00, 0, w, g);
    chk("accept_after_hs", w, 0);

    req_valid = 2'b01;
    req_a0 = 16'h00F0; req_b0 = 16'h000F;
    n = 0;
    @(negedge clk);
    while (rdy === 2'b00 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("rst_pre_grant", rdy, 1);
    @(posedge clk);
    #1 req_valid = 2'b00;
    @(negedge clk);
    chk("rst_pre_busy", bz, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_idle_out("rst_exec");
    @(posedge clk);
    #1 rst = 1'b0;
    last_rr = 1;
    repeat (E + 3) begin
      @(negedge clk);
      chk("rst_no_resp", rv, 0);
      chk("rst_no_busy", bz, 0);
    end
    @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) begin
      run_op(2'b11, 16'($urandom), 16'($urandom),
             16'($urandom), 16'($urandom), 2'b11, 0, w, g);
      chk("rr_seq", g, (i % 2) ? 2'b10 : 2'b01);
    end

    for (int i = 0; i < 16; i++) begin
      v = 2'($urandom_range(1, 3));
      run_op(v, 16'($urandom), 16'($urandom),
             16'($urandom), 16'($urandom), 2'b00,
             int'($urandom_range(0, 3)), w, g);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
